// File: rtl/icache_assoc.sv
// icache_assoc: set-associative, read-only instruction cache.
//
// A fetch hits combinationally in IDLE when exactly one way of the indexed
// set holds a valid line with a matching tag. A miss latches the block
// address and refills the line word by word from memory, then returns to
// IDLE where the still-pending fetch hits. Replacement takes the lowest
// invalid way, otherwise a per-set round-robin pointer. A flush clears every
// valid bit and pointer in a single cycle. Data words are never cleared.
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   asynchronous active-high reset
//   imemREN   in   fetch request
//   imemaddr  in   fetch byte address (word aligned)
//   flush     in   invalidate all lines
//   ihit      out  fetch served this cycle
//   imemload  out  fetched word, 0 when ihit=0
//   busy      out  refill or flush in progress
//   iREN      out  memory read request
//   iaddr     out  memory word address
//   iwait     in   memory stall (0 = iload valid)
//   iload     in   memory read data
module icache_assoc #(
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int IIDX_W    = 3,
  parameter int WAYS      = 2,
  parameter int BLK_WORDS = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              busy,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int TAG_W = ADDR_W - IIDX_W - OFF_W - 2;
  localparam int SETS  = 1 << IIDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int MC_W  = $clog2(WAYS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

  state_t            state_q;
  logic              valid_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAY_W-1:0]  vptr_q  [SETS];
  logic [WORD_W-1:0] data_q  [SETS][WAYS][BLK_WORDS];
  logic [WORD_W-1:0] fill_q  [BLK_WORDS];
  logic [CNT_W-1:0]  cnt_q;
  logic [TAG_W-1:0]  ftag_q;
  logic [IIDX_W-1:0] fidx_q;
  logic [ADDR_W-1:0] iaddr_q;
  logic              iren_q;
  logic              busy_q;

  // Address fields of the incoming fetch
  logic [TAG_W-1:0]  req_tag;
  logic [IIDX_W-1:0] req_idx;
  logic [CNT_W-1:0]  req_off;
  logic [ADDR_W-1:0] req_base;
  logic              unused_byte_bits;

  assign req_tag  = imemaddr[ADDR_W-1 -: TAG_W];
  assign req_idx  = imemaddr[2+OFF_W +: IIDX_W];
  assign req_base = {imemaddr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign unused_byte_bits = ^imemaddr[1:0];

  generate
    if (OFF_W > 0) begin : g_off
      assign req_off = imemaddr[2 +: OFF_W];
    end else begin : g_no_off
      assign req_off = '0;
    end
  endgenerate

  // Per-way tag compare on the fetch set, and valid bits of the refill set
  logic [WAYS-1:0] way_match;
  logic [WAYS-1:0] fill_set_valid;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_match[gi]      = valid_q[req_idx][gi] && (tag_q[req_idx][gi] == req_tag);
      assign fill_set_valid[gi] = valid_q[fidx_q][gi];
    end
  endgenerate

  logic [MC_W-1:0]  match_cnt;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    match_cnt = '0;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_match[w]) begin
        match_cnt = match_cnt + MC_W'(1);
        hit_way   = WAY_W'(w);
      end
    end
  end

  // A hit requires a single matching way; duplicate matches are treated as a miss
  assign ihit     = !RST && (state_q == IDLE) && imemREN && !flush && (match_cnt == MC_W'(1));
  assign imemload = ihit ? data_q[req_idx][hit_way][req_off] : '0;

  // Victim: lowest invalid way wins; the round-robin pointer only when the set is full
  logic [WAY_W-1:0] victim;
  logic             vic_from_ptr;
  logic [WAY_W-1:0] vptr_d;

  always_comb begin
    victim       = vptr_q[fidx_q];
    vic_from_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!fill_set_valid[w]) begin
        victim       = WAY_W'(w);
        vic_from_ptr = 1'b0;
      end
    end
    vptr_d = WAY_W'((int'(vptr_q[fidx_q]) + 1) % WAYS);
  end

  // Last word arriving this cycle completes the line unless a flush overrides it
  logic line_we;
  assign line_we = (state_q == REFILL) && !flush && !iwait && (cnt_q == LAST);

  // Line data has no reset; the final word comes straight from iload
  always_ff @(posedge CLK) begin
    if (line_we) begin
      for (int w = 0; w < BLK_WORDS; w++) begin
        data_q[fidx_q][victim][w] <= (w == BLK_WORDS - 1) ? iload : fill_q[w];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ftag_q  <= '0;
      fidx_q  <= '0;
      iaddr_q <= '0;
      iren_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        vptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
        end
      end
      for (int b = 0; b < BLK_WORDS; b++) begin
        fill_q[b] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q <= FLUSH;
            busy_q  <= 1'b1;
          end else if (imemREN && !ihit) begin
            state_q <= REFILL;
            ftag_q  <= req_tag;
            fidx_q  <= req_idx;
            cnt_q   <= '0;
            iaddr_q <= req_base;
            iren_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REFILL: begin
          if (flush) begin
            // Partial fill is abandoned; nothing is written
            state_q <= FLUSH;
            cnt_q   <= '0;
            iaddr_q <= '0;
            iren_q  <= 1'b0;
          end else if (!iwait) begin
            fill_q[cnt_q] <= iload;
            if (cnt_q == LAST) begin
              valid_q[fidx_q][victim] <= 1'b1;
              tag_q[fidx_q][victim]   <= ftag_q;
              if (vic_from_ptr) begin
                vptr_q[fidx_q] <= vptr_d;
              end
              state_q <= IDLE;
              cnt_q   <= '0;
              iaddr_q <= '0;
              iren_q  <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              iaddr_q <= iaddr_q + ADDR_W'(4);
            end
          end
        end
        FLUSH: begin
          for (int s = 0; s < SETS; s++) begin
            vptr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
              valid_q[s][w] <= 1'b0;
            end
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign iREN  = iren_q;
  assign iaddr = iaddr_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Testbench for icache_assoc.
// A directed DUT (default parameters) exercises reset, cold miss timing,
// memory stalls, replacement, flush and reset during refill. Five further
// DUTs (WAYS/BLK_WORDS sweep plus defaults) run random fetch streams; each
// fetch pushes its expected word and hit/miss outcome into a scoreboard
// queue that a monitor pops whenever the DUT asserts ihit. The reference
// model treats every set as a FIFO of resident blocks, which is the
// behaviour the fill-invalid-first / round-robin rule produces.
module tb_icache_assoc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
  } sb_t;

  // Memory contents: a bijective scramble of the word address
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a ^ 32'hA5A5_0F0F) * 32'h9E37_79B1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // ---------------------------------------------------------------- directed DUT
  logic        d_rst, d_ren, d_flush, d_ihit, d_busy, d_iren, d_iwait;
  logic [31:0] d_addr, d_load, d_iaddr, d_iload;
  logic        r_rst;

  icache_assoc u_dut (
    .CLK(clk), .RST(d_rst), .imemREN(d_ren), .imemaddr(d_addr), .flush(d_flush),
    .ihit(d_ihit), .imemload(d_load), .busy(d_busy), .iREN(d_iren), .iaddr(d_iaddr),
    .iwait(d_iwait), .iload(d_iload)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a fetch until ihit; w = stall cycles before each memory word.
  // lat = cycles from the request's first cycle to the hit cycle.
  task automatic do_fetch(input logic [31:0] a, input int w, output int lat);
    int          wc;
    logic        prev_stall;
    logic [31:0] prev_addr;
    wc = 0; prev_stall = 1'b0; prev_addr = '0; lat = -1;
    d_addr = a; d_ren = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (prev_stall && d_iren) chk("iaddr_hold", d_iaddr, prev_addr);
      d_iwait = d_iren && (wc < w);
      d_iload = d_iwait ? $urandom : memfn(d_iaddr);
      #1;
      if (d_ihit) begin
        lat = k;
        break;
      end
      prev_stall = d_iren && d_iwait;
      prev_addr  = d_iaddr;
      if (d_iren) wc = d_iwait ? wc + 1 : 0;
      tick();
    end
    if (lat < 0) begin
      n_chk++;
      $display("FAIL fetch_timeout: addr %0h got no ihit required ihit=1", a);
    end else begin
      chk($sformatf("fetch_data_%0h", a), d_load, memfn(a));
    end
    d_ren = 1'b0; d_iwait = 1'b0;
    tick();
  endtask

  task automatic do_flush();
    d_flush = 1'b1; d_ren = 1'b0;
    tick();
    chk("flush_busy", d_busy, 1);
    chk("flush_iren", d_iren, 0);
    d_flush = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------- random DUTs
  bit rdone [5];

  for (genvar gi = 0; gi < 5; gi++) begin : g_rand
    localparam int RW = (gi == 4) ? 2 : ((gi >= 2) ? 4 : 1);
    localparam int RB = (gi == 4) ? 2 : ((gi % 2 == 1) ? 8 : 1);

    logic        ren, flsh, ihit, busy, iren, iwait;
    logic [31:0] addr, load, iaddr, iload;
    sb_t         sb_q [$];
    int unsigned fifo [8][$];
    int unsigned req_cyc;

    icache_assoc #(.WAYS(RW), .BLK_WORDS(RB)) u_dut (
      .CLK(clk), .RST(r_rst), .imemREN(ren), .imemaddr(addr), .flush(flsh),
      .ihit(ihit), .imemload(load), .busy(busy), .iREN(iren), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
    );

    // Reference: resident blocks per set, oldest first
    function automatic bit m_access(input logic [31:0] a);
      int unsigned blk, s;
      blk = a / (4 * RB);
      s   = blk % 8;
      for (int i = 0; i < fifo[s].size(); i++) begin
        if (fifo[s][i] == blk) return 1'b1;
      end
      if (fifo[s].size() == RW) void'(fifo[s].pop_front());
      fifo[s].push_back(blk);
      return 1'b0;
    endfunction

    // Memory responder with random stalls
    initial begin
      iwait = 1'b0; iload = '0;
      forever begin
        @(posedge clk);
        #1;
        iwait = ($urandom_range(0, 2) != 0);
        iload = iwait ? $urandom : memfn(iaddr);
      end
    end

    // Stimulus: one fetch at a time, occasional flush between fetches
    initial begin
      sb_t         e;
      logic [31:0] a;
      int          k;
      ren = 1'b0; flsh = 1'b0; addr = '0; req_cyc = 0;
      rdone[gi] = 1'b0;
      @(negedge r_rst);
      @(posedge clk);
      #1;
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 24) == 0) begin
          ren = 1'b0; flsh = 1'b1;
          for (int s = 0; s < 8; s++) fifo[s].delete();
          @(posedge clk);
          #1;
          flsh = 1'b0;
        end
        a = $urandom_range(0, 63) << 2;
        e.addr = a;
        e.data = memfn(a);
        e.hit  = m_access(a);
        sb_q.push_back(e);
        req_cyc = cyc;
        addr = a; ren = 1'b1;
        k = 0;
        while (sb_q.size() != 0 && k < 3000) begin
          @(posedge clk);
          #1;
          k++;
        end
        if (sb_q.size() != 0) begin
          n_chk++;
          $display("FAIL cfg%0d_timeout: addr %0h got no ihit required ihit=1", gi, a);
          sb_q.delete();
          break;
        end
      end
      ren = 1'b0;
      rdone[gi] = 1'b1;
    end

    // Monitor: compare every served fetch against the scoreboard head
    initial begin
      sb_t e;
      forever begin
        @(negedge clk);
        if (ihit) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL cfg%0d_spurious_hit: got ihit=1 addr %0h required ihit=0", gi, addr);
          end else begin
            e = sb_q.pop_front();
            chk($sformatf("cfg%0d_data_%0h", gi, e.addr), load, e.data);
            chk($sformatf("cfg%0d_hitflag_%0h", gi, e.addr), 32'(cyc == req_cyc), 32'(e.hit));
          end
        end
      end
    end
  end

  function automatic bit all_done();
    for (int i = 0; i < 5; i++) if (!rdone[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------- directed sequence
  initial begin
    int lat;
    d_rst = 1'b1; d_ren = 1'b1; d_addr = 32'h40; d_flush = 1'b0;
    d_iwait = 1'b0; d_iload = '0;
    r_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ihit", d_ihit, 0);
    chk("rst_imemload", d_load, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_iren", d_iren, 0);
    chk("rst_iaddr", d_iaddr, 0);
    d_rst = 1'b0; d_ren = 1'b0; r_rst = 1'b0;
    tick();

    // Cold miss at 0x40 with no memory stalls
    d_ren = 1'b1; d_addr = 32'h40; d_iwait = 1'b0;
    #1;
    chk("cold_ihit", d_ihit, 0);
    chk("idle_busy", d_busy, 0);
    tick();
    d_iload = memfn(d_iaddr);
    #1;
    chk("refill_iren", d_iren, 1);
    chk("refill_iaddr0", d_iaddr, 32'h40);
    chk("refill_busy", d_busy, 1);
    chk("refill_ihit", d_ihit, 0);
    tick();
    d_iload = memfn(d_iaddr);
    #1;
    chk("refill_iaddr1", d_iaddr, 32'h44);
    tick();
    chk("fill_hit", d_ihit, 1);
    chk("fill_data", d_load, memfn(32'h40));
    chk("idle_iren", d_iren, 0);
    chk("idle_iaddr", d_iaddr, 0);
    d_ren = 1'b0;
    tick();
    do_fetch(32'h44, 0, lat);
    chk("lat_hit_44", lat, 0);

    // Three stall cycles per word
    do_flush();
    do_fetch(32'h80, 3, lat);
    chk("lat_wait3", lat, 9);

    // Replacement in set 0
    do_flush();
    do_fetch(32'h000, 0, lat); chk("lat_000_cold", lat, 3);
    do_fetch(32'h100, 0, lat); chk("lat_100_cold", lat, 3);
    do_fetch(32'h200, 0, lat); chk("lat_200_evict", lat, 3);
    do_fetch(32'h100, 0, lat); chk("lat_100_resident", lat, 0);
    do_fetch(32'h000, 0, lat); chk("lat_000_evicted", lat, 3);

    // Flush on the last refill word
    do_flush();
    do_fetch(32'h100, 0, lat); chk("lat_100_fill", lat, 3);
    do_fetch(32'h100, 0, lat); chk("lat_100_hit", lat, 0);
    d_ren = 1'b1; d_addr = 32'h300; d_iwait = 1'b0;
    tick();
    d_iload = memfn(d_iaddr);
    tick();
    d_flush = 1'b1;
    d_iload = memfn(d_iaddr);
    #1;
    chk("flush_mid_iaddr", d_iaddr, 32'h304);
    tick();
    d_flush = 1'b0;
    #1;
    chk("flush_state_busy", d_busy, 1);
    chk("flush_state_ihit", d_ihit, 0);
    d_ren = 1'b0;
    tick();
    do_fetch(32'h100, 0, lat); chk("lat_100_after_flush", lat, 3);
    do_fetch(32'h300, 0, lat); chk("lat_300_not_written", lat, 3);

    // Reset in the middle of a stalled refill
    do_fetch(32'h40, 0, lat); chk("lat_40_refill", lat, 3);
    d_ren = 1'b1; d_addr = 32'h140; d_iwait = 1'b1;
    tick();
    chk("pre_rst_iren", d_iren, 1);
    d_rst = 1'b1;
    #1;
    chk("async_rst_iren", d_iren, 0);
    chk("async_rst_busy", d_busy, 0);
    tick();
    d_rst = 1'b0; d_ren = 1'b0; d_iwait = 1'b0;
    tick();
    do_fetch(32'h40, 0, lat); chk("lat_40_after_rst", lat, 3);

    for (int k = 0; k < 60000; k++) begin
      if (all_done()) break;
      @(posedge clk);
    end
    if (!all_done()) begin
      n_chk++;
      $display("FAIL random_streams: got unfinished streams required all finished");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter WORD_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter IIDX_W, default 3, set index width (2^IIDX_W sets).
REQ-004 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-005 SHALL have parameter BLK_WORDS, default 2, words per line; power of two, 1..8.
REQ-006 SHALL derive OFF_W = log2(BLK_WORDS) and TAG_W = ADDR_W - IIDX_W - OFF_W - 2.
REQ-007 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-008 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port imemREN  input  1  datapath fetch request.
REQ-010 SHALL have port imemaddr  input  ADDR_W  fetch byte address, word aligned.
REQ-011 SHALL have port flush  input  1  invalidate all lines.
REQ-012 SHALL have port ihit  output  1  fetch served this cycle.
REQ-013 SHALL have port imemload  output  WORD_W  fetched instruction, valid when ihit=1.
REQ-014 SHALL have port busy  output  1  refill or flush in progress.
REQ-015 SHALL have port iREN  output  1  memory read request.
REQ-016 SHALL have port iaddr  output  ADDR_W  memory word address.
REQ-017 SHALL have port iwait  input  1  memory stall; 0 = iload valid this cycle.
REQ-018 SHALL have port iload  input  WORD_W  memory read data.

Function
REQ-019 SHALL split imemaddr as tag[ADDR_W-1 -: TAG_W], index, word offset (OFF_W bits), byte offset [1:0] ignored.
REQ-020 SHALL store per line: valid bit, TAG_W tag, BLK_WORDS data words; per set: victim pointer of log2(WAYS) bits (0 when WAYS=1).
REQ-021 SHALL use FSM states IDLE, REFILL, FLUSH.
REQ-022 In IDLE, ihit SHALL be combinational: 1 iff imemREN=1, flush=0, and exactly one way of the indexed set is valid with equal tag; imemload = that line's word at the offset, else 0.
REQ-023 In IDLE with imemREN=1, flush=0 and no hit, SHALL latch block base address (offset and byte bits zeroed) and go to REFILL next cycle.
REQ-024 In REFILL, SHALL drive iREN=1, iaddr = latched base + 4*word counter; counter starts 0, increments on each cycle with iwait=0, capturing iload into a fill buffer.
REQ-025 On the cycle the last word (counter = BLK_WORDS-1) returns with iwait=0, SHALL write the full line, valid=1, tag, into the victim way and go to IDLE; the request hits on the following cycle (miss latency = 1 + sum of memory word latencies + 1).
REQ-026 Victim SHALL be lowest-index invalid way of the set; if all valid, the set's victim pointer; pointer SHALL advance by 1 mod WAYS only when it was used.
REQ-027 ihit SHALL be 0 throughout REFILL and FLUSH; imemaddr changes or imemREN=0 during REFILL SHALL NOT abort the refill (line completes on latched address).
REQ-028 flush=1 in IDLE or REFILL SHALL go to FLUSH next cycle, abandoning any partial refill (no line written); FLUSH lasts one cycle clearing all valid bits and victim pointers, then IDLE.
REQ-029 iREN and iaddr SHALL be 0 in IDLE and FLUSH; busy = 1 in REFILL and FLUSH.
REQ-030 Data arrays SHALL NOT be cleared by flush; only valid bits matter.

Reset
REQ-031 RST=1 SHALL immediately force IDLE, all valid bits, tags, victim pointers, counter and fill buffer to 0; outputs ihit=0, imemload=0, busy=0, iREN=0, iaddr=0.
REQ-032 RST asserted mid-REFILL SHALL discard the fill; after release first fetch misses.

Verification
REQ-033 Cold fetch 0x0000_0040, iwait=0 always -> REFILL issues iaddr 0x40 then 0x44, line written, ihit=1 with word from 0x40 one cycle later; fetch 0x44 then hits with no iREN.
REQ-034 iwait held 1 for 3 cycles per word -> iaddr held stable, counter holds, ihit first asserts after 9 cycles from miss.
REQ-035 Defaults, fetch 0x000, 0x100, 0x200 (same set 0) -> fills way0, way1, then evicts way0; 0x100 still hits, 0x000 misses.
REQ-036 flush asserted on second refill word -> FLUSH one cycle, no line written, previously resident 0x100 misses afterward.
REQ-037 RST pulsed mid-REFILL with iwait=1 -> iREN=0 and busy=0 same cycle; all prior lines miss after release.
REQ-038 Sweep WAYS in {1,4}, BLK_WORDS in {1,8}: random fetch stream checked against reference memory model, no wrong imemload when ihit=1.
